// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 request path: command and response
// codes, sequencer states and byte positions inside the 40-bit frame.
package dht11_pkg;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_TEMP   = 8'h01;
    localparam logic [7:0] CMD_HUM    = 8'h02;

    localparam logic [7:0] RSP_OK      = 8'h07;
    localparam logic [7:0] RSP_FAULT   = 8'h1F;
    localparam logic [7:0] RSP_TEMP    = 8'h09;
    localparam logic [7:0] RSP_HUM     = 8'h08;
    localparam logic [7:0] RSP_CKSUM   = 8'hDF;
    localparam logic [7:0] RSP_INVALID = 8'hEF;

    // LSB position of each byte in {hum_int, hum_dec, temp_int, temp_dec, checksum}
    localparam int HUM_INT_LSB  = 32;
    localparam int HUM_DEC_LSB  = 24;
    localparam int TEMP_INT_LSB = 16;
    localparam int TEMP_DEC_LSB = 8;
    localparam int CKSUM_LSB    = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_RELEASE,
        ST_MEASURE,
        ST_EVALUATE,
        ST_RESPOND
    } state_t;

    function automatic logic [7:0] frame_byte(input logic [39:0] frame,
                                              input int lsb);
        return frame[lsb +: 8];
    endfunction

endpackage

// File: rtl/dht11_frame_check.sv
// Combinational frame decoder: checksum validation and integer fields.
// Ports: frame (40-bit sensor frame) -> checksum_ok, temp_int, hum_int.
module dht11_frame_check
    import dht11_pkg::*;
(
    input  logic [39:0] frame,
    output logic        checksum_ok,
    output logic [7:0]  temp_int,
    output logic [7:0]  hum_int
);

    logic [7:0] sum;

    // 8-bit truncated sum of the four data bytes
    assign sum = frame_byte(frame, HUM_INT_LSB)
               + frame_byte(frame, HUM_DEC_LSB)
               + frame_byte(frame, TEMP_INT_LSB)
               + frame_byte(frame, TEMP_DEC_LSB);

    assign checksum_ok = (sum == frame_byte(frame, CKSUM_LSB));
    assign temp_int    = frame_byte(frame, TEMP_INT_LSB);
    assign hum_int     = frame_byte(frame, HUM_INT_LSB);

endmodule

// File: rtl/dht11_request_controller.sv
// Command sequencer in front of the DHT11 block: accepts a host command,
// pulses the sensor block through reset, starts a read, waits for done
// (with timeout), checks the frame and returns a code/data response.
// Ports: clock, reset_n; request_valid/request_code/request_ready (command
// in); enable_sensor, dados_sensor, erro, done (sensor block);
// response_valid/response_code/response_data/response_ready (response out).
module dht11_request_controller
    import dht11_pkg::*;
#(
    parameter int CLOCK_HZ       = 50_000_000,
    parameter int LOW_CYCLES     = 100,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        request_valid,
    input  logic [7:0]  request_code,
    output logic        request_ready,
    output logic        enable_sensor,
    input  logic [39:0] dados_sensor,
    input  logic        erro,
    input  logic        done,
    output logic        response_valid,
    output logic [7:0]  response_code,
    output logic [7:0]  response_data,
    input  logic        response_ready
);

    localparam int MAX_CYCLES =
        (LOW_CYCLES > TIMEOUT_CYCLES) ? LOW_CYCLES : TIMEOUT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] LOW_LAST     = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    if (CLOCK_HZ <= 0 || LOW_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("dht11_request_controller: parameters must be positive");
    end

    state_t      state;
    logic [CW-1:0] count;
    logic [7:0]  cmd_q;
    logic [39:0] frame_q;
    logic        erro_q;

    logic        checksum_ok;
    logic [7:0]  temp_int;
    logic [7:0]  hum_int;

    dht11_frame_check u_frame_check (
        .frame       (frame_q),
        .checksum_ok (checksum_ok),
        .temp_int    (temp_int),
        .hum_int     (hum_int)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            count          <= '0;
            cmd_q          <= '0;
            frame_q        <= '0;
            erro_q         <= 1'b0;
            request_ready  <= 1'b0;
            enable_sensor  <= 1'b0;
            response_valid <= 1'b0;
            response_code  <= '0;
            response_data  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    request_ready <= 1'b1;
                    if (request_valid && request_ready) begin
                        cmd_q         <= request_code;
                        request_ready <= 1'b0;
                        state         <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (cmd_q > CMD_HUM) begin
                        response_code  <= RSP_INVALID;
                        response_data  <= 8'h00;
                        response_valid <= 1'b1;
                        state          <= ST_RESPOND;
                    end else begin
                        count <= '0;
                        state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (count == LOW_LAST) begin
                        count         <= '0;
                        enable_sensor <= 1'b1;
                        state         <= ST_MEASURE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    // done takes priority over a coincident timeout
                    if (done) begin
                        frame_q       <= dados_sensor;
                        erro_q        <= erro;
                        enable_sensor <= 1'b0;
                        state         <= ST_EVALUATE;
                    end else if (count == TIMEOUT_LAST) begin
                        erro_q        <= 1'b1;
                        enable_sensor <= 1'b0;
                        state         <= ST_EVALUATE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_EVALUATE: begin
                    response_valid <= 1'b1;
                    state          <= ST_RESPOND;
                    if (erro_q) begin
                        response_code <= RSP_FAULT;
                        response_data <= 8'h00;
                    end else if (!checksum_ok) begin
                        response_code <= RSP_CKSUM;
                        response_data <= 8'h00;
                    end else if (cmd_q == CMD_TEMP) begin
                        response_code <= RSP_TEMP;
                        response_data <= temp_int;
                    end else if (cmd_q == CMD_HUM) begin
                        response_code <= RSP_HUM;
                        response_data <= hum_int;
                    end else begin
                        response_code <= RSP_OK;
                        response_data <= 8'h00;
                    end
                end
                ST_RESPOND: begin
                    if (response_ready) begin
                        response_valid <= 1'b0;
                        request_ready  <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_request_controller.sv
// Directed bench for dht11_request_controller with a small inline sensor
// model (done/erro/frame driven from the scenario tasks).
module tb_dht11_request_controller;

    localparam int LOW = 10;
    localparam int TMO = 50;
    localparam logic [39:0] GOOD = 40'h37_00_19_00_50;
    localparam logic [39:0] BAD  = 40'h37_00_19_00_51;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        request_valid = 1'b0;
    logic [7:0]  request_code = 8'h00;
    logic        request_ready;
    logic        enable_sensor;
    logic [39:0] dados_sensor = '0;
    logic        erro = 1'b0;
    logic        done = 1'b0;
    logic        response_valid;
    logic [7:0]  response_code;
    logic [7:0]  response_data;
    logic        response_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    int         low_cnt;
    int         lat;
    logic       en_after;
    logic [7:0] rc;
    logic [7:0] rd;

    always #5 clock = ~clock;

    dht11_request_controller #(
        .CLOCK_HZ       (100_000_000),
        .LOW_CYCLES     (LOW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .request_valid  (request_valid),
        .request_code   (request_code),
        .request_ready  (request_ready),
        .enable_sensor  (enable_sensor),
        .dados_sensor   (dados_sensor),
        .erro           (erro),
        .done           (done),
        .response_valid (response_valid),
        .response_code  (response_code),
        .response_data  (response_data),
        .response_ready (response_ready)
    );

    task automatic send_request(input logic [7:0] code);
        int w;
        @(negedge clock);
        request_valid = 1'b1;
        request_code  = code;
        w = 0;
        while (!request_ready && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (!request_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_wait: request_ready=%0b required 1", request_ready);
        end
        @(negedge clock);
        request_valid = 1'b0;
        request_code  = 8'h00;
    endtask

    task automatic run_sensor(input logic [7:0] code, input logic [39:0] frame,
                              input logic err, input int delay);
        logic rose;
        send_request(code);
        low_cnt = 0;
        rose = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (enable_sensor) begin
                rose = 1'b1;
                break;
            end
            low_cnt++;
        end
        if (!rose) begin
            n_cmp++;
            n_bad++;
            $display("FAIL enable_wait: enable_sensor=0 required rise");
        end
        if (delay >= 0) begin
            repeat (delay) @(negedge clock);
            dados_sensor = frame;
            erro = err;
            done = 1'b1;
        end
        lat = 0;
        en_after = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            lat++;
            if (lat == 1) en_after = enable_sensor;
            if (response_valid) break;
        end
        if (!response_valid) begin
            n_cmp++;
            n_bad++;
            $display("FAIL response_wait: response_valid=0 required 1");
        end
        rc = response_code;
        rd = response_data;
    endtask

    task automatic accept_response(output logic rv_after, output logic rdy_after);
        @(negedge clock);
        response_ready = 1'b1;
        @(negedge clock);
        response_ready = 1'b0;
        done = 1'b0;
        erro = 1'b0;
        rv_after  = response_valid;
        rdy_after = request_ready;
    endtask

    task automatic test_reset;
        @(negedge clock);
        n_cmp++;
        if ({request_ready, enable_sensor, response_valid, response_code, response_data}
            !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy=%0b en=%0b rv=%0b code=%h data=%h required all 0",
                     request_ready, enable_sensor, response_valid, response_code, response_data);
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_cmp++;
        if (request_ready !== 1'b1 || enable_sensor !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: rdy=%0b en=%0b required 1/0",
                     request_ready, enable_sensor);
        end
    endtask

    task automatic test_temperature;
        logic rv_a, rdy_a;
        run_sensor(8'h01, GOOD, 1'b0, 3);
        n_cmp++;
        if (low_cnt !== LOW) begin
            n_bad++;
            $display("FAIL temp_low_cycles: got %0d required %0d", low_cnt, LOW);
        end
        n_cmp++;
        if (en_after !== 1'b0 || lat !== 2) begin
            n_bad++;
            $display("FAIL temp_latency: en=%0b lat=%0d required 0/2", en_after, lat);
        end
        n_cmp++;
        if (rc !== 8'h09 || rd !== 8'h19) begin
            n_bad++;
            $display("FAIL temp_response: got %h/%h required 09/19", rc, rd);
        end
        accept_response(rv_a, rdy_a);
        n_cmp++;
        if (rv_a !== 1'b0 || rdy_a !== 1'b1) begin
            n_bad++;
            $display("FAIL temp_accept: rv=%0b rdy=%0b required 0/1", rv_a, rdy_a);
        end
    endtask

    task automatic test_humidity;
        logic rv_a, rdy_a;
        run_sensor(8'h02, GOOD, 1'b0, 0);
        n_cmp++;
        if (rc !== 8'h08 || rd !== 8'h37) begin
            n_bad++;
            $display("FAIL hum_response: got %h/%h required 08/37", rc, rd);
        end
        accept_response(rv_a, rdy_a);
    endtask

    task automatic test_status;
        logic rv_a, rdy_a;
        run_sensor(8'h00, GOOD, 1'b0, 5);
        n_cmp++;
        if (rc !== 8'h07 || rd !== 8'h00) begin
            n_bad++;
            $display("FAIL status_response: got %h/%h required 07/00", rc, rd);
        end
        accept_response(rv_a, rdy_a);
    endtask

    task automatic test_checksum;
        logic rv_a, rdy_a;
        run_sensor(8'h01, BAD, 1'b0, 2);
        n_cmp++;
        if (rc !== 8'hDF || rd !== 8'h00) begin
            n_bad++;
            $display("FAIL cksum_response: got %h/%h required DF/00", rc, rd);
        end
        accept_response(rv_a, rdy_a);
    endtask

    task automatic test_sensor_error;
        logic rv_a, rdy_a;
        run_sensor(8'h02, GOOD, 1'b1, 4);
        n_cmp++;
        if (rc !== 8'h1F || rd !== 8'h00) begin
            n_bad++;
            $display("FAIL erro_response: got %h/%h required 1F/00", rc, rd);
        end
        accept_response(rv_a, rdy_a);
    endtask

    task automatic test_timeout;
        logic rv_a, rdy_a;
        run_sensor(8'h01, GOOD, 1'b0, -1);
        n_cmp++;
        if (lat !== TMO + 1) begin
            n_bad++;
            $display("FAIL timeout_latency: got %0d required %0d", lat, TMO + 1);
        end
        n_cmp++;
        if (rc !== 8'h1F || rd !== 8'h00) begin
            n_bad++;
            $display("FAIL timeout_response: got %h/%h required 1F/00", rc, rd);
        end
        accept_response(rv_a, rdy_a);
    endtask

    task automatic test_invalid;
        logic rv_a, rdy_a;
        logic rv0;
        send_request(8'h05);
        rv0 = response_valid;
        @(negedge clock);
        n_cmp++;
        if (rv0 !== 1'b0 || response_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL invalid_latency: rv@N+1=%0b rv@N+2=%0b required 0/1",
                     rv0, response_valid);
        end
        n_cmp++;
        if (response_code !== 8'hEF || response_data !== 8'h00 || enable_sensor !== 1'b0) begin
            n_bad++;
            $display("FAIL invalid_response: got %h/%h en=%0b required EF/00 en=0",
                     response_code, response_data, enable_sensor);
        end
        accept_response(rv_a, rdy_a);
    endtask

    task automatic test_hold;
        int bad;
        bad = 0;
        run_sensor(8'h01, GOOD, 1'b0, 1);
        request_valid = 1'b1;
        request_code  = 8'h02;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (response_valid !== 1'b1 || response_code !== 8'h09 ||
                response_data !== 8'h19 || request_ready !== 1'b0 ||
                enable_sensor !== 1'b0)
                bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL hold_stable: %0d unstable cycles required 0", bad);
        end
        request_valid = 1'b0;
        response_ready = 1'b1;
        @(negedge clock);
        response_ready = 1'b0;
        done = 1'b0;
        bad = 0;
        for (int i = 0; i < 2 * LOW; i++) begin
            @(negedge clock);
            if (enable_sensor !== 1'b0 || response_valid !== 1'b0 || request_ready !== 1'b1)
                bad++;
        end
        n_cmp++;
        if (bad !== 0) begin
            n_bad++;
            $display("FAIL hold_no_queue: %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_reset_measure;
        int bad;
        send_request(8'h01);
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (enable_sensor) break;
        end
        repeat (5) @(negedge clock);
        n_cmp++;
        if (enable_sensor !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pre: enable_sensor=%0b required 1", enable_sensor);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({request_ready, enable_sensor, response_valid, response_code, response_data}
            !== 19'd0) begin
            n_bad++;
            $display("FAIL rst_async: rdy=%0b en=%0b rv=%0b code=%h data=%h required all 0",
                     request_ready, enable_sensor, response_valid, response_code, response_data);
        end
        @(negedge clock);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < TMO + 2 * LOW; i++) begin
            @(negedge clock);
            if (response_valid !== 1'b0 || enable_sensor !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0 || request_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_discard: %0d active cycles rdy=%0b required 0/1",
                     bad, request_ready);
        end
    endtask

    initial begin
        test_reset();
        test_temperature();
        test_humidity();
        test_status();
        test_checksum();
        test_sensor_error();
        test_timeout();
        test_invalid();
        test_hold();
        test_reset_measure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dht11_request_controller.md
# dht11_request_controller

Command-side sequencer that sits directly upstream of the DHT11 communication block and consumes its result. It accepts one-byte commands from the host-link decoder and drives the sensor block's `enable_sensor` to start a measurement. It then waits for `done`, validates the 40-bit frame checksum and returns a response code/data byte pair over a valid/ready handshake.

## Interface
- `CLOCK_HZ`, 50_000_000: system clock frequency; documentation only.
- `LOW_CYCLES`, 100: cycles `enable_sensor` is held low before each measurement (sensor-block reset pulse).
- `TIMEOUT_CYCLES`, 50_000_000: cycles to wait for `done` after raising `enable_sensor` (1 s at 50 MHz).
- `clock`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `request_valid`  in  1  command byte present.
- `request_code`  in  8  command: 0x00 status, 0x01 temperature, 0x02 humidity.
- `request_ready`  out  1  high only in IDLE; a command is accepted when valid & ready.
- `enable_sensor`  out  1  to sensor block; low holds it in reset, a rising edge starts a read.
- `dados_sensor`  in  40  frame {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first.
- `erro`  in  1  sensor block timed out (meaningful with `done`).
- `done`  in  1  level, sensor block finished; held until `enable_sensor` falls.
- `response_valid`  out  1  response present; held until accepted.
- `response_code`  out  8  result code (see Operation).
- `response_data`  out  8  payload byte; 0x00 when the code carries no data.
- `response_ready`  in  1  consumer accepts the response when valid & ready.

## Operation
- Response codes: 0x07 sensor OK, 0x1F sensor fault, 0x09 temperature, 0x08 humidity, 0xDF checksum error, 0xEF invalid command.
- States: IDLE, DECODE, RELEASE, MEASURE, EVALUATE, RESPOND.
- IDLE: `request_ready`=1, `enable_sensor`=0. On valid & ready, latch `request_code` and go to DECODE.
- DECODE: for code > 0x02, load 0xEF/0x00 and go to RESPOND (no sensor access). Otherwise clear the counter and go to RELEASE.
- RELEASE: `enable_sensor`=0 for exactly LOW_CYCLES cycles, then go to MEASURE with the counter cleared.
- MEASURE: `enable_sensor`=1. If `done`=1, latch `dados_sensor` and `erro`, then go to EVALUATE. If the counter reaches TIMEOUT_CYCLES-1 without `done`, treat it as `erro`=1. When `done` and timeout occur in the same cycle, `done` wins.
- EVALUATE (one cycle, `enable_sensor` returns to 0):
  - If `erro` is set, respond 0x1F/0x00.
  - Else if the checksum is wrong, respond 0xDF/0x00. Checksum: (b4+b3+b2+b1) mod 256 == b0, using an 8-bit truncated sum.
  - Else by command: 0x00 → 0x07/0x00; 0x01 → 0x09/temp_int (bits 23:16); 0x02 → 0x08/hum_int (bits 39:32).
  - Then go to RESPOND.
- RESPOND: `response_valid`=1 with code/data stable. On `response_ready`, return to IDLE; the command is then complete.
- `request_valid` is ignored outside IDLE; no queuing.
- Decimal bytes (b3, b1) are checked by the checksum but never output.

## Timing
- Reset values: `request_ready`=0 during reset, 1 from the first cycle after release. `enable_sensor`=0, `response_valid`=0, `response_code`=0x00, `response_data`=0x00. State is IDLE, counter 0.
- Invalid command accepted at edge N: `response_valid`=1 from N+2.
- Sensor command accepted at N:
  - `enable_sensor` low through N+1+LOW_CYCLES.
  - `enable_sensor` high from N+2+LOW_CYCLES.
  - `done` seen at edge M: `response_valid` at M+2; `enable_sensor` low from M+1.
- Timeout: `response_valid`=1 with 0x1F exactly TIMEOUT_CYCLES+1 cycles after `enable_sensor` rises.
- `response_valid` falls the cycle after the accepting edge; `request_ready` rises the same cycle.
- `reset_n` low mid-operation: all outputs go to reset values immediately (asynchronous). An in-flight command and its response are discarded.
- Counter width: $clog2(max(LOW_CYCLES, TIMEOUT_CYCLES))+1; it must not wrap.

## Structure
- Package `dht11_pkg`: command codes, response codes, state enum, frame byte-index constants.
- Sub-module `dht11_frame_check` (combinational): inputs 40-bit frame; outputs checksum_ok, temp_int, hum_int. It is reusable by later stages.
- Counter and FSM stay in this module.

## Test plan
- Request 0x01; model returns `done` with frame 0x37_00_19_00_50 → response 0x09/0x19; `enable_sensor` low exactly LOW_CYCLES cycles first.
- Request 0x02, same frame → 0x08/0x37. Request 0x00 → 0x07/0x00.
- Frame 0x37_00_19_00_51 → 0xDF/0x00.
- Model asserts `done` with `erro`=1 → 0x1F/0x00. Model never asserts `done` (small TIMEOUT_CYCLES) → 0x1F after TIMEOUT_CYCLES+1 cycles.
- Request 0x05 → 0xEF/0x00 at N+2; `enable_sensor` never rises.
- Hold `response_ready`=0 for 20 cycles: code/data stable and a new `request_valid` is ignored. Assert `reset_n` low during MEASURE: outputs go to reset values and no response is emitted.
